aes_dec_round_ctrl: RTL
=======================

Name: aes_dec_round_ctrl

Overview:
Iterative AES-128 inverse-cipher sequencer. It accepts one 128-bit ciphertext over a valid/ready handshake and runs the initial AddRoundKey, then 9 full inverse rounds, then the final round, one round per clock. Each full round is InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns; the final round omits InvMixColumns. The block owns the state register, round counter and key-index sequencing, and instantiates the team's existing combinational inverse round primitives. Round keys come from an external expanded-key store with a combinational read.

Parameters:
NR, 10, number of rounds; only 10 (AES-128) is supported.
KIDX_W, 4, width of the round-key index.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  ciphertext valid
in_ready  out  1  block can accept ciphertext
in_data  in  128  ciphertext, byte 0 at [127:120]
key_idx  out  KIDX_W  round-key index presented to the key store
round_key  in  128  round key for key_idx, same cycle (combinational read)
out_valid  out  1  plaintext valid
out_ready  in  1  downstream accepts plaintext
out_data  out  128  plaintext (the state register)
busy  out  1  high in ROUND, FINAL or DONE
abort  in  1  synchronous cancel back to IDLE

Behaviour:
- Reset (rst_n=0, asynchronous): FSM=IDLE, round=0, state=0. in_ready=1, out_valid=0, busy=0, out_data=0.
- FSM states: IDLE, ROUND, FINAL, DONE.
- key_idx is combinational from the FSM:
  - IDLE: key_idx=10.
  - ROUND: key_idx=round.
  - FINAL: key_idx=0.
  - DONE: key_idx=0.
- IDLE: in_ready=1.
  - Accept on in_valid&in_ready: state<=in_data^round_key (key 10), round<=9, go to ROUND.
  - in_valid low: hold.
- ROUND:
  - Each cycle: state<=InvMixColumns(InvSubBytes(InvShiftRows(state))^round_key); round<=round-1.
  - When round==1 on that edge, go to FINAL (round<=0).
  - Exactly 9 ROUND cycles per block (keys 9 down to 1).
- FINAL: state<=InvSubBytes(InvShiftRows(state))^round_key (key 0); go to DONE.
- DONE: out_valid=1, out_data stable.
  - out_ready=1: go to IDLE, out_valid falls next cycle.
  - out_ready=0: hold indefinitely; state and out_data stay unchanged.
- Handshakes:
  - in_ready=0 in ROUND, FINAL and DONE. No input is accepted while busy; there is no overlap with the next block.
  - After a DONE handshake, the next ciphertext can be accepted in the following IDLE cycle (one idle bubble).
- Latency: out_valid rises 10 clock edges after the accepting edge. Throughput is one block per 12 cycles when out_ready is held high.
- Handshake rules: in_data is sampled only on the accepting edge. out_data is meaningful only while out_valid=1. out_valid does not depend combinationally on out_ready.
- abort:
  - Effective in any state: next edge FSM=IDLE, round=0, out_valid=0. State is not cleared.
  - abort takes priority over acceptance, so in IDLE with in_valid=1, abort=1 nothing is accepted.
  - abort in DONE together with out_ready also discards the result and returns to IDLE.
- Reset mid-operation aborts immediately; no partial output is produced.
- round never wraps: it is only decremented in ROUND, and the FSM leaves ROUND at round==1.

Test Plan:
- FIPS-197 C.1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, key store returns key10=13111d7fe3944a17f307a78b4d2b30c5. Drive in_data=69c4e0d86a7b0430d8cdb78070b4c55a, out_ready=1.
  - Required: out_data=00112233445566778899aabbccddeeff, with out_valid high exactly 10 edges after acceptance.
- key_idx trace: starting from acceptance, key_idx reads 10,9,8,...,1,0 on consecutive cycles, and in_ready=0 from the cycle after acceptance until IDLE.
- Backpressure:
  - Stimulus: out_ready=0 for 20 cycles after DONE.
  - Required: out_valid stays 1 and out_data stays constant. in_valid pulses during this time are ignored (in_ready=0). Raising out_ready gives one transfer, then out_valid=0.
- Back-to-back: two ciphertexts (C.1 vector, then the all-zero block) with in_valid held high. Second acceptance occurs 12 cycles after the first. Both outputs are correct.
- Abort:
  - Stimulus: assert abort in the 5th ROUND cycle.
  - Required: next cycle FSM is IDLE, in_ready=1, out_valid never asserted. A fresh C.1 run afterwards produces the correct plaintext.
- Async reset: drop rst_n mid-ROUND between clock edges. All outputs go to their reset values immediately, without a clock edge. After release, IDLE with key_idx=10.

Source files
------------

// File: rtl/aes_dec_round_ctrl.sv
// Iterative AES-128 inverse-cipher sequencer: one inverse round per clock,
// owning the state register, round counter and round-key index.
module aes_dec_round_ctrl #(
    parameter int unsigned NR     = 10,
    parameter int unsigned KIDX_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      in_data,
    output logic [KIDX_W-1:0] key_idx,
    input  logic [127:0]      round_key,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      out_data,
    output logic              busy,
    input  logic              abort
);
    localparam int unsigned BLK_W = 128;

    // Inverse S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_e;

    fsm_e              fsm;
    logic [KIDX_W-1:0] round;
    logic [BLK_W-1:0]  state;
    logic [BLK_W-1:0]  inv_core;
    logic [BLK_W-1:0]  round_out;

    function automatic logic [7:0] byte_at(input logic [BLK_W-1:0] s, input int i);
        return s[127 - 8*i -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Row r rotates right by r byte positions; bytes are column-major.
    function automatic logic [BLK_W-1:0] inv_shift_rows(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = byte_at(s, 4*((c + 4 - r) % 4) + r);
            end
        end
        return o;
    endfunction

    function automatic logic [BLK_W-1:0] inv_sub_bytes(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127 - 8*i -: 8] = INV_SBOX[(255 - int'(byte_at(s, i))) * 8 +: 8];
        end
        return o;
    endfunction

    function automatic logic [BLK_W-1:0] inv_mix_columns(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] =
                    gmul(byte_at(s, 4*c + r),           4'he) ^
                    gmul(byte_at(s, 4*c + (r + 1) % 4), 4'hb) ^
                    gmul(byte_at(s, 4*c + (r + 2) % 4), 4'hd) ^
                    gmul(byte_at(s, 4*c + (r + 3) % 4), 4'h9);
            end
        end
        return o;
    endfunction

    // Shared round datapath; FINAL takes the result before InvMixColumns.
    always_comb begin
        inv_core  = inv_sub_bytes(inv_shift_rows(state)) ^ round_key;
        round_out = inv_mix_columns(inv_core);
    end

    always_comb begin
        key_idx = '0;
        case (fsm)
            IDLE:    key_idx = KIDX_W'(NR);
            ROUND:   key_idx = round;
            default: key_idx = '0;
        endcase
    end

    assign out_data = state;

    // Sequencer; abort wins over every transition including acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            round     <= '0;
            state     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (abort) begin
            fsm       <= IDLE;
            round     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state    <= in_data ^ round_key;
                        round    <= KIDX_W'(NR - 1);
                        fsm      <= ROUND;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ROUND: begin
                    state <= round_out;
                    round <= round - KIDX_W'(1);
                    if (round == KIDX_W'(1)) fsm <= FINAL;
                end
                FINAL: begin
                    state     <= inv_core;
                    fsm       <= DONE;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        fsm       <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule
